// File: rtl/tc_pkg.sv
// Shared state encodings, FP32 constants and the TF32 multiply / FP32 add
// arithmetic used by every multiply-accumulate cell.
package tc_pkg;
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] COMPUTE = 2'd1;
    localparam logic [1:0] DONE    = 2'd2;

    localparam logic [31:0] FP32_ZERO = 32'h0000_0000;
    localparam logic [31:0] FP32_ONE  = 32'h3F80_0000;
    localparam logic [31:0] TF32_MASK = 32'hFFFF_E000;

    // Operands are cut to a 10-bit mantissa, so the 11x11-bit significand
    // product is exact and needs no rounding. Subnormal inputs count as zero.
    function automatic logic [31:0] tf32mul(input logic [31:0] x, input logic [31:0] y);
        logic [31:0] xa, ya;
        logic [47:0] p;
        logic [22:0] m;
        logic        s;
        int          e;
        xa = x & TF32_MASK;
        ya = y & TF32_MASK;
        s  = xa[31] ^ ya[31];
        if (xa[30:23] == 8'hFF || ya[30:23] == 8'hFF) begin
            if (xa[22:0] != 0 || ya[22:0] != 0 || xa[30:23] == 0 || ya[30:23] == 0)
                return 32'h7FC0_0000;
            return {s, 8'hFF, 23'h0};
        end
        if (xa[30:23] == 0 || ya[30:23] == 0) return {s, 31'h0};
        p = {24'h0, 1'b1, xa[22:0]} * {24'h0, 1'b1, ya[22:0]};
        e = int'(xa[30:23]) + int'(ya[30:23]) - 127 + int'(p[47]);
        m = p[47] ? p[46:24] : p[45:23];
        if (e >= 255) return {s, 8'hFF, 23'h0};
        if (e <= 0)   return {s, 31'h0};
        return {s, e[7:0], m};
    endfunction

    // Round-to-nearest-even add with guard/round/sticky; subnormals count as zero.
    function automatic logic [31:0] fpADD32(input logic [31:0] x, input logic [31:0] y);
        logic [31:0] p, q;
        logic [26:0] mp, mq, sh;
        logic [27:0] s;
        logic [24:0] r;
        int          e, d;
        if (x[30:23] == 8'hFF) return x;
        if (y[30:23] == 8'hFF) return y;
        if (x[30:23] == 0) return y;
        if (y[30:23] == 0) return x;
        if (x[30:0] >= y[30:0]) begin p = x; q = y; end
        else begin p = y; q = x; end
        mp = {1'b1, p[22:0], 3'b000};
        mq = {1'b1, q[22:0], 3'b000};
        d  = int'(p[30:23]) - int'(q[30:23]);
        e  = int'(p[30:23]);
        if (d > 26) sh = 27'd1;
        else begin
            sh    = mq >> d;
            sh[0] = sh[0] | (|(mq & ((27'd1 << d) - 27'd1)));
        end
        if (p[31] == q[31]) s = {1'b0, mp} + {1'b0, sh};
        else                s = {1'b0, mp} - {1'b0, sh};
        if (s == 0) return FP32_ZERO;
        if (s[27]) begin
            s = {1'b0, s[27:2], s[1] | s[0]};
            e = e + 1;
        end else begin
            for (int i = 0; i < 26; i++)
                if (!s[26]) begin s = s << 1; e = e - 1; end
        end
        r = {1'b0, s[26:3]} + {24'h0, s[2] & (s[1] | s[0] | s[3])};
        if (r[24]) begin r = r >> 1; e = e + 1; end
        if (e >= 255) return {p[31], 8'hFF, 23'h0};
        if (e <= 0)   return {p[31], 31'h0};
        return {p[31], e[7:0], r[22:0]};
    endfunction
endpackage

// File: rtl/tc_mac_cell.sv
// One output element: TF32 multiply feeding an FP32 accumulator register.
module tc_mac_cell
    import tc_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        seed,
    input  logic        step,
    input  logic [31:0] seed_val,
    input  logic [31:0] a_op,
    input  logic [31:0] b_op,
    output logic [31:0] acc
);
    always_ff @(posedge clk) begin
        if (rst)       acc <= FP32_ZERO;
        else if (seed) acc <= seed_val;
        else if (step) acc <= fpADD32(acc, tf32mul(a_op, b_op));
    end
endmodule

// File: rtl/tensor_core_seq_mma.sv
// Sequential D = A*B + C: M*N MAC cells consume one k-slice per clock.
module tensor_core_seq_mma
    import tc_pkg::*;
#(
    parameter int M = 4,
    parameter int N = 4,
    parameter int K = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       acc_mode,
    input  logic [0:M-1][0:K-1][31:0]  a,
    input  logic [0:K-1][0:N-1][31:0]  b,
    input  logic [0:M-1][0:N-1][31:0]  c,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [0:M-1][0:N-1][31:0]  d
);
    localparam int KW = (K > 1) ? $clog2(K) : 1;

    logic [1:0]                state;
    logic [KW-1:0]             k;
    logic [0:M-1][0:K-1][31:0] a_q;
    logic [0:K-1][0:N-1][31:0] b_q;
    logic                      accept, seed, step;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign accept    = in_ready && in_valid;
    // Chaining simply skips the seed so the accumulators keep the last result.
    assign seed      = accept && !acc_mode;
    assign step      = (state == COMPUTE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            k     <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    state <= COMPUTE;
                    k     <= '0;
                end
                COMPUTE: begin
                    if (k == KW'(K - 1)) begin
                        state <= DONE;
                        k     <= '0;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                DONE: if (out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            a_q <= a;
            b_q <= b;
        end
    end

    for (genvar gi = 0; gi < M; gi++) begin : g_row
        for (genvar gj = 0; gj < N; gj++) begin : g_col
            tc_mac_cell u_cell (
                .clk      (clk),
                .rst      (rst),
                .seed     (seed),
                .step     (step),
                .seed_val (c[gi][gj]),
                .a_op     (a_q[gi][k]),
                .b_op     (b_q[k][gj]),
                .acc      (d[gi][gj])
            );
        end
    end
endmodule

// File: tb/tb_tensor_core_seq_mma.sv
// Directed bench for tensor_core_seq_mma with a queue of expected result matrices.
module tb_tensor_core_seq_mma;
    typedef logic [0:3][0:3][31:0] mat_t;

    logic clk = 1'b0;
    logic rst, in_valid, in_ready, acc_mode, out_valid, out_ready;
    mat_t a, b, c, d;

    int   checks = 0;
    int   errors = 0;
    mat_t exp_q[$];
    mat_t cur;
    int   lat;

    tensor_core_seq_mma #(.M(4), .N(4), .K(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .acc_mode(acc_mode), .a(a), .b(b), .c(c),
        .out_valid(out_valid), .out_ready(out_ready), .d(d)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_mat(input string tag, input mat_t exp);
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                chk($sformatf("%s_d%0d%0d", tag, i, j), d[i][j], exp[i][j]);
    endtask

    function automatic mat_t fill(input logic [31:0] v);
        mat_t m;
        for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) m[i][j] = v;
        return m;
    endfunction

    function automatic mat_t ident(input logic [31:0] diag, input logic [31:0] off);
        mat_t m;
        for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) m[i][j] = (i == j) ? diag : off;
        return m;
    endfunction

    // Drive operands at a negedge; the following posedge accepts them.
    task automatic accept(input string tag, input mat_t ta, input mat_t tb, input mat_t tc,
                          input logic mode, input logic push, input mat_t exp, input logic hold);
        chk({tag, "_in_ready"}, {31'h0, in_ready}, 32'h1);
        a = ta; b = tb; c = tc; acc_mode = mode; in_valid = 1'b1;
        if (push) exp_q.push_back(exp);
        @(negedge clk);
        in_valid = hold;
        chk({tag, "_busy"}, {31'h0, in_ready}, 32'h0);
    endtask

    // Called at the negedge after accept; expects out_valid after K more edges.
    task automatic wait_result(input string tag, output mat_t exp);
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_latency"}, 32'(lat), 32'd4);
        exp = exp_q.size() != 0 ? exp_q.pop_front() : fill(32'hDEAD_BEEF);
        chk_mat(tag, exp);
    endtask

    task automatic drain(input string tag);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_idle_in_ready"}, {31'h0, in_ready}, 32'h1);
        chk({tag, "_idle_out_valid"}, {31'h0, out_valid}, 32'h0);
    endtask

    initial begin
        mat_t a6;
        rst = 1'b1; in_valid = 1'b0; acc_mode = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; c = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", {31'h0, in_ready}, 32'h1);
        chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
        chk_mat("rst", fill(32'h0));

        // Identity * 2.0 + 1.0 = 3.0 everywhere
        accept("t1", ident(32'h3F80_0000, 32'h0), fill(32'h4000_0000), fill(32'h3F80_0000),
               1'b0, 1'b1, fill(32'h4040_0000), 1'b0);
        wait_result("t1", cur);
        drain("t1");

        // Ones * ones with in_valid held high: re-accept only after the handshake
        accept("t2", fill(32'h3F80_0000), fill(32'h3F80_0000), fill(32'h0),
               1'b0, 1'b1, fill(32'h4080_0000), 1'b1);
        wait_result("t2a", cur);
        chk("t2_hold_in_ready", {31'h0, in_ready}, 32'h0);
        exp_q.push_back(fill(32'h4080_0000));
        drain("t2");
        @(negedge clk);
        in_valid = 1'b0;
        chk("t2_reaccept", {31'h0, in_ready}, 32'h0);
        wait_result("t2b", cur);
        drain("t2b");

        // Chain onto 4.0 with identity*identity
        accept("t3", ident(32'h3F80_0000, 32'h0), ident(32'h3F80_0000, 32'h0), fill(32'h4120_0000),
               1'b1, 1'b1, ident(32'h40A0_0000, 32'h4080_0000), 1'b0);
        wait_result("t3", cur);
        drain("t3");

        // Backpressure with a stray in_valid pulse in DONE
        accept("t4", ident(32'h3F80_0000, 32'h0), fill(32'h4000_0000), fill(32'h3F80_0000),
               1'b0, 1'b1, fill(32'h4040_0000), 1'b0);
        wait_result("t4", cur);
        for (int n = 0; n < 10; n++) begin
            if (n == 5) begin a = fill(32'h4100_0000); c = fill(32'h0); in_valid = 1'b1; end
            else in_valid = 1'b0;
            @(negedge clk);
            chk("t4_out_valid", {31'h0, out_valid}, 32'h1);
            chk("t4_in_ready", {31'h0, in_ready}, 32'h0);
            chk("t4_d00", d[0][0], cur[0][0]);
            chk("t4_d33", d[3][3], cur[3][3]);
        end
        in_valid = 1'b0;
        chk_mat("t4_stable", cur);
        drain("t4");

        // Reset mid-COMPUTE at k=2, then chain from zero
        accept("t5", fill(32'h3F80_0000), fill(32'h3F80_0000), fill(32'h3F80_0000),
               1'b0, 1'b0, fill(32'h0), 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t5_in_ready", {31'h0, in_ready}, 32'h1);
        chk("t5_out_valid", {31'h0, out_valid}, 32'h0);
        chk_mat("t5_rst", fill(32'h0));
        accept("t5b", fill(32'h3F80_0000), fill(32'h3F80_0000), fill(32'h3F80_0000),
               1'b1, 1'b1, fill(32'h4080_0000), 1'b0);
        wait_result("t5b", cur);
        drain("t5b");

        // TF32 truncation drops the low mantissa bits of A[0][0]
        a6 = fill(32'h0);
        a6[0][0] = 32'h3F80_0FFF;
        cur = fill(32'h0);
        cur[0][0] = 32'h3F80_0000;
        accept("t6", a6, ident(32'h3F80_0000, 32'h0), fill(32'h0), 1'b0, 1'b1, cur, 1'b0);
        wait_result("t6", cur);
        drain("t6");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/tensor_core_seq_mma.md
Name: tensor_core_seq_mma

Overview:
Parametrised, sequential successor to the combinational 4x4 TF32 tensor core. Computes D = A×B + C for an M×K by K×N TF32 product with FP32 accumulation, one k-slice per clock. It uses M×N multiply-accumulate cells instead of M×N×K multipliers and an adder tree. Valid/ready handshakes on input and output, plus an accumulate-chaining mode, let the block sit behind an operand-staging buffer in the GEMM datapath.

Parameters:
M, 4, rows of A, C, D
N, 4, columns of B, C, D
K, 4, inner dimension (≥1); equals compute cycles per operation
KW, $clog2(K) (min 1), k-counter width (derived, not overridable)

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
in_valid  input  1  operand set valid
in_ready  output  1  block accepts operands
acc_mode  input  1  0: accumulator seeded from c; 1: seeded from previous result
a[0:M-1][0:K-1]  input  32 each  FP32 operands, TF32-truncated in multiply
b[0:K-1][0:N-1]  input  32 each  FP32 operands, TF32-truncated in multiply
c[0:M-1][0:N-1]  input  32 each  FP32 addend
out_valid  output  1  d holds a completed result
out_ready  input  1  consumer takes result
d[0:M-1][0:N-1]  output  32 each  FP32 result (accumulator registers)

Behaviour:
- Reset (synchronous, rst=1 at clk edge):
  - State goes to IDLE; k counter=0.
  - All accumulators (and therefore d) = 32'h0000_0000.
  - out_valid=0; in_ready=1 the cycle after reset.
  - Reset overrides every other input, including mid-COMPUTE and DONE; an in-flight operation is discarded.
- FSM states IDLE, COMPUTE, DONE:
  - IDLE: in_ready=1. On in_valid:
    - latch a and b into operand registers
    - acc ← c (acc_mode=0) or keep acc (acc_mode=1)
    - k←0; go to COMPUTE.
  - COMPUTE: in_ready=0, out_valid=0.
    - Each cycle: acc[i][j] ← fpADD32(acc[i][j], tf32mul(A[i][k], B[k][j])).
    - k increments. After the step with k=K-1, go to DONE.
  - DONE: out_valid=1, in_ready=0; d stable.
    - On out_ready go to IDLE next cycle.
    - in_valid is ignored in COMPUTE and DONE. There is no overlap of accept and drain.
- Latency: accept at edge t gives out_valid=1 after edge t+K. This is K+1 cycles from accept to the first out_valid cycle. Throughput is one operation per K+2 cycles with out_ready held high.
- Accumulation order is sequential in k (fixed, decided). Results may differ in the last ULP from tree-summed hardware; the golden model must use the same order.
- acc_mode=1 after reset with no prior operation seeds from zero, so D = A×B.
- d is the accumulator register itself. Its value during COMPUTE is a partial sum and is undefined to consumers; only out_valid qualifies it.
- Operand registers hold the latched a/b, so inputs may change freely after acceptance.
- K=1: COMPUTE lasts one cycle; the counter never wraps.
- FP arithmetic is fully delegated to tf32mul and fpADD32, with no added rounding or flushing.

Decomposition:
- Package tc_pkg:
  - state enum (IDLE, COMPUTE, DONE)
  - FP32 constants (FP32_ZERO, FP32_ONE)
  - TF32 mantissa mask 32'hFFFF_E000 for the bench model
- Sub-module tc_mac_cell:
  - contains one tf32mul, one fpADD32 and a 32-bit accumulator register with seed/step/hold controls
  - instantiated M×N in a generate loop
- Top holds the FSM, the k counter, the operand registers and the column/row mux of A[i][k] and B[k][j].

Test Plan:
1. A=identity (3F800000 diag, 0 elsewhere), B all 40000000, C all 3F800000, acc_mode=0 → out_valid exactly K+1 cycles after accept; all d=40400000 (3.0).
2. A all 3F800000, B all 3F800000, C all 0 → all d=40800000 (4.0). in_valid held high throughout: second operation accepted only in the cycle after the out_ready handshake.
3. Chaining: run test 2, then acc_mode=1 with A=B=identity → diagonal d=40A00000 (5.0), off-diagonal d=40800000.
4. Backpressure: out_ready=0 for 10 cycles after out_valid → d and out_valid stable, in_ready=0, a pulsed in_valid is not accepted; out_ready=1 → IDLE next cycle.
5. rst=1 while k=2 → next cycle IDLE, out_valid=0, all d=0. Then acc_mode=1 with test-2 operands → d all 40800000.
6. TF32 truncation: A[0][0]=3F800FFF, B=identity, C=0 → d[0][0]=3F800000.
